// File: rtl/mux_rr_arbiter_if.sv
// Stream bundle shared by the two requesters, the downstream consumer and the arbiter.
// master = sources/consumer side, slave = arbiter side.
interface mux_rr_arbiter_if #(
    parameter int DW = 8
);
    logic          in0_valid;
    logic [DW-1:0] in0_data;
    logic          in0_last;
    logic          in0_ready;
    logic          in1_valid;
    logic [DW-1:0] in1_data;
    logic          in1_last;
    logic          in1_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          sel;
    logic          busy;

    modport master (
        output in0_valid, in0_data, in0_last,
        output in1_valid, in1_data, in1_last,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_valid, out_data, out_last,
        input  sel, busy
    );

    modport slave (
        input  in0_valid, in0_data, in0_last,
        input  in1_valid, in1_data, in1_last,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_valid, out_data, out_last,
        output sel, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter driving a registered 2:1 select between two streams.
// A grant is held until the last beat transfers or the granted source idles too long.
module mux_rr_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst,
    mux_rr_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | no grant; arbitrate on valids using prio
    // GNT0  | in0 owns the output until its last beat or timeout
    // GNT1  | in1 owns the output until its last beat or timeout
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic          prio;
    logic          prio_nxt;
    logic          sel;
    logic          sel_nxt;
    logic [7:0]    idle_cnt;
    logic [7:0]    idle_cnt_nxt;
    logic          g_id;
    logic          g_valid;
    logic          g_last;
    logic          other_valid;
    logic [DW-1:0] mux_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            sel      <= 1'b0;
            idle_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            sel      <= sel_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        g_id        = (state == GNT1);
        g_valid     = g_id ? bus.in1_valid : bus.in0_valid;
        g_last      = g_id ? bus.in1_last  : bus.in0_last;
        other_valid = g_id ? bus.in0_valid : bus.in1_valid;
    end

    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        idle_cnt_nxt = 8'd0;
        case (state)
            IDLE: begin
                if (bus.in0_valid && bus.in1_valid) begin
                    state_nxt = prio ? GNT1 : GNT0;
                end else if (bus.in0_valid) begin
                    state_nxt = GNT0;
                end else if (bus.in1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (g_valid && bus.out_ready && g_last) begin
                    prio_nxt = ~g_id;
                    // hand straight over to a waiting peer so back-to-back packets see no bubble
                    if (other_valid) begin
                        state_nxt = g_id ? GNT0 : GNT1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (!g_valid && (idle_cnt == IDLE_LIMIT)) begin
                    prio_nxt  = ~g_id;
                    state_nxt = IDLE;
                end else if (!g_valid && (idle_cnt != 8'hFF)) begin
                    idle_cnt_nxt = idle_cnt + 8'd1;
                end else if (!g_valid) begin
                    idle_cnt_nxt = idle_cnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (state_nxt == GNT1) begin
            sel_nxt = 1'b1;
        end else if (state_nxt == GNT0) begin
            sel_nxt = 1'b0;
        end else begin
            sel_nxt = sel;
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.in0_ready = 1'b0;
        bus.in1_ready = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            GNT0: begin
                bus.out_valid = bus.in0_valid;
                bus.out_last  = bus.in0_last;
                bus.in0_ready = bus.out_ready;
            end
            GNT1: begin
                bus.out_valid = bus.in1_valid;
                bus.out_last  = bus.in1_last;
                bus.in1_ready = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign mux_data     = sel ? bus.in1_data : bus.in0_data;
    assign bus.out_data = mux_data;
    assign bus.sel      = sel;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed packets push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_mux_rr_arbiter;
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sel;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    int    xfer_count = 0;
    int    c0;
    int    c1;
    beat_t exp_q[$];
    beat_t mon_exp;

    mux_rr_arbiter_if #(.DW(8)) bus ();

    mux_rr_arbiter #(.DW(8), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic s);
        beat_t b;
        b.data = d;
        b.last = l;
        b.sel  = s;
        exp_q.push_back(b);
    endtask

    task automatic set_in(input int port, input logic v, input logic [7:0] d, input logic l);
        if (port == 0) begin
            bus.in0_valid = v;
            bus.in0_data  = d;
            bus.in0_last  = l;
        end else begin
            bus.in1_valid = v;
            bus.in1_data  = d;
            bus.in1_last  = l;
        end
    endtask

    // Sends n beats base, base+1, ...; close marks the final beat as last.
    task automatic send(input int port, input logic [7:0] base, input int n,
                        input logic close, output int cycles);
        logic acc;
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            set_in(port, 1'b1, base + 8'(i), close && (i == n - 1));
            acc = 1'b0;
            while (!acc && cycles < 60) begin
                @(negedge clk);
                acc = (port == 0) ? bus.in0_ready : bus.in1_ready;
                @(posedge clk);
                #1;
                cycles++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: port %0d beat %0d got no ready expected ready", port, i);
                break;
            end
        end
        set_in(port, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", bus.out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat{data,last,sel}", {bus.out_data, bus.out_last, bus.sel},
                      {mon_exp.data, mon_exp.last, mon_exp.sel});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        // T1: reset holds everything quiet even with both requesters valid
        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_in(0, 1'b1, 8'h11, 1'b0);
        set_in(1, 1'b1, 8'h22, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in0_ready", bus.in0_ready, 0);
        check("rst_in1_ready", bus.in1_ready, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // T2: single requester, one arbitration cycle then back-to-back beats
        expect_beat(8'hA1, 1'b0, 1'b1);
        expect_beat(8'hA2, 1'b0, 1'b1);
        expect_beat(8'hA3, 1'b1, 1'b1);
        send(1, 8'hA1, 3, 1'b1, c1);
        check("t2_cycles", c1, 4);
        drain("t2_drain");
        @(negedge clk);
        check("t2_busy_after", bus.busy, 0);
        check("t2_sel_held", bus.sel, 1);

        // T3: contention, in0 first then in1 with no bubble, prio back to in0
        do_reset();
        expect_beat(8'h10, 1'b0, 1'b0);
        expect_beat(8'h11, 1'b1, 1'b0);
        expect_beat(8'h20, 1'b0, 1'b1);
        expect_beat(8'h21, 1'b1, 1'b1);
        fork
            send(0, 8'h10, 2, 1'b1, c0);
            send(1, 8'h20, 2, 1'b1, c1);
        join
        check("t3_in0_cycles", c0, 3);
        check("t3_in1_cycles", c1, 5);
        drain("t3_drain");
        expect_beat(8'h30, 1'b1, 1'b0);
        expect_beat(8'h40, 1'b1, 1'b1);
        fork
            send(0, 8'h30, 1, 1'b1, c0);
            send(1, 8'h40, 1, 1'b1, c1);
        join
        check("t3b_in0_cycles", c0, 2);
        check("t3b_in1_cycles", c1, 3);
        drain("t3b_drain");

        // T4: 5 cycles of backpressure exceed TIMEOUT=4 but must not release
        do_reset();
        expect_beat(8'h50, 1'b0, 1'b0);
        expect_beat(8'h51, 1'b0, 1'b0);
        expect_beat(8'h52, 1'b1, 1'b0);
        base = xfer_count;
        fork
            send(0, 8'h50, 3, 1'b1, c0);
            begin
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while ((xfer_count - base) < 1 && k < 50);
                check("t4_first_beat", xfer_count - base, 1);
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("t4_stall{valid,data,sel,busy,rdy}",
                          {bus.out_valid, bus.out_data, bus.sel, bus.busy, bus.in0_ready},
                          {1'b1, 8'h51, 1'b0, 1'b1, 1'b0});
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        check("t4_cycles", c0, 9);
        drain("t4_drain");

        // T5: in0 stalls after a non-last beat, timeout hands over to in1
        do_reset();
        expect_beat(8'h60, 1'b0, 1'b0);
        expect_beat(8'h70, 1'b1, 1'b1);
        fork
            send(0, 8'h60, 1, 1'b0, c0);
            send(1, 8'h70, 1, 1'b1, c1);
        join
        check("t5_in0_cycles", c0, 2);
        check("t5_in1_cycles", c1, 8);
        drain("t5_drain");

        // T6: reset during beat 2 of 4 drops the grant at once
        do_reset();
        expect_beat(8'h80, 1'b0, 1'b0);
        set_in(0, 1'b1, 8'h80, 1'b0);
        set_in(1, 1'b1, 8'h90, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        set_in(0, 1'b1, 8'h81, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst{valid,r0,r1,busy,sel}",
              {bus.out_valid, bus.in0_ready, bus.in1_ready, bus.busy, bus.sel}, 5'b00000);
        check("t6_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        expect_beat(8'hA0, 1'b0, 1'b0);
        expect_beat(8'hA1, 1'b1, 1'b0);
        expect_beat(8'h90, 1'b1, 1'b1);
        fork
            send(0, 8'hA0, 2, 1'b1, c0);
            send(1, 8'h90, 1, 1'b1, c1);
        join
        check("t6_in0_cycles", c0, 3);
        check("t6_in1_cycles", c1, 4);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
